// File: rtl/alu_pkg.sv
// alu_pkg
// Definitions shared by the ALU command issuer and its response buffer:
//   - opcode constants understood by the downstream ALU
//   - bit positions inside the 5-bit response flag vector
//   - issuer FSM state type
//   - helper that classifies a flag vector as an error response
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_AND    = 4'b0010;
    localparam logic [3:0] OP_OR     = 4'b0011;
    localparam logic [3:0] OP_XOR    = 4'b0100;
    localparam logic [3:0] OP_NOT    = 4'b0101;
    localparam logic [3:0] OP_SHL    = 4'b0110;
    localparam logic [3:0] OP_SHR    = 4'b0111;
    localparam logic [3:0] OP_CMP_EQ = 4'b1000;
    localparam logic [3:0] OP_CMP_LT = 4'b1001;

    // Flag vector layout: {is_less, is_equal, invalid_op, underflow, overflow}
    localparam int FLAG_OVF = 0;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INV = 2;
    localparam int FLAG_EQ  = 3;
    localparam int FLAG_LT  = 4;
    localparam int NFLAGS   = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } issuer_state_e;

    function automatic logic flags_have_error(input logic [NFLAGS-1:0] flags);
        return flags[FLAG_OVF] | flags[FLAG_UNF] | flags[FLAG_INV];
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo
// Small FIFO that holds completed ALU responses until the consumer takes them.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (empties the buffer)
//   push_i       write wdata_i at the tail
//   wdata_i      response word {result, flags, tag}
//   pop_i        drop the head entry (ignored when empty)
//   rdata_o      head entry, valid whenever empty_o is low
//   empty_o      buffer empty
//   count_o      number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module alu_rsp_fifo
    import alu_pkg::*;
#(
    parameter int DW    = 25,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [DW-1:0]              wdata_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              rdata_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop_ok;

    assign pop_ok = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_i, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
// Issues commands to an external ALU with one register stage of latency,
// tracks the two in-flight slots, and buffers results so that no response
// is ever dropped while the consumer stalls. A drain request stops new
// commands until everything in flight has been delivered, then pulses
// drain_done for one cycle.
//
// Build option: define ALU_ISSUER_STATS_EN to enable the statistics counters
// (stat_issued counts accepts, stat_errors counts error responses and
// saturates). Without it both statistics outputs are tied to zero.
//
// State table:
//   state    | meaning
//   ST_RUN   | accepting commands while buffer space is available
//   ST_DRAIN | no new commands; waiting for in-flight and buffered responses
//   ST_DONE  | drain complete, drain_done high for this single cycle
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_a, cmd_b, cmd_op, cmd_tag   command payload
//   alu_a, alu_b, alu_op            registered ALU operand/opcode drive
//   alu_result, alu_overflow, alu_underflow, alu_invalid_op,
//   alu_is_equal, alu_is_less       registered ALU outputs
//   rsp_valid/rsp_ready             response handshake
//   rsp_result, rsp_flags, rsp_tag  response payload (FIFO order)
//   drain_req, drain_done           drain request / one-cycle completion pulse
//   stat_issued, stat_errors        statistics
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [WIDTH-1:0]    cmd_a,
    input  logic [WIDTH-1:0]    cmd_b,
    input  logic [3:0]          cmd_op,
    input  logic [TAGW-1:0]     cmd_tag,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [3:0]          alu_op,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic                alu_overflow,
    input  logic                alu_underflow,
    input  logic                alu_invalid_op,
    input  logic                alu_is_equal,
    input  logic                alu_is_less,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_result,
    output logic [NFLAGS-1:0]   rsp_flags,
    output logic [TAGW-1:0]     rsp_tag,
    input  logic                drain_req,
    output logic                drain_done,
    output logic [15:0]         stat_issued,
    output logic [7:0]          stat_errors
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;
    localparam int DW = WIDTH + NFLAGS + TAGW;

    issuer_state_e      state_q, state_d;
    logic [WIDTH-1:0]   alu_a_q, alu_b_q;
    logic [3:0]         alu_op_q;
    logic               v0_q, v1_q;
    logic [TAGW-1:0]    tag0_q, tag1_q;

    logic               accept, push, pop, pipe_idle;
    logic [NFLAGS-1:0]  alu_flags;
    logic [DW-1:0]      fifo_wdata, fifo_rdata;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [OW-1:0]      occupancy;

    assign accept    = cmd_valid && cmd_ready;
    // Stage 1 holds the command whose ALU result is registered right now.
    assign push      = v1_q;
    assign pop       = rsp_valid && rsp_ready;
    assign pipe_idle = !v0_q && !v1_q;

    assign alu_flags  = {alu_is_less, alu_is_equal, alu_invalid_op, alu_underflow, alu_overflow};
    assign fifo_wdata = {alu_result, alu_flags, tag1_q};

    // Every accepted command reserves a buffer slot until it is popped, so
    // in-flight commands count against free space.
    assign occupancy = OW'(fifo_count) + OW'(v0_q) + OW'(v1_q);
    assign cmd_ready = (state_q == ST_RUN) && (occupancy < OW'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= OP_ADD;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            tag0_q   <= '0;
            tag1_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_a_q  <= cmd_a;
                alu_b_q  <= cmd_b;
                alu_op_q <= cmd_op;
                tag0_q   <= cmd_tag;
            end
            v0_q   <= accept;
            v1_q   <= v0_q;
            tag1_q <= tag0_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN: if (pipe_idle && fifo_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    assign drain_done = (state_q == ST_DONE);

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;

    alu_rsp_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign {rsp_result, rsp_flags, rsp_tag} = fifo_rdata;

`ifdef ALU_ISSUER_STATS_EN
    logic [15:0] stat_issued_q, stat_issued_d;
    logic [7:0]  stat_errors_q, stat_errors_d;

    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_errors_d = stat_errors_q;
        if (accept) begin
            stat_issued_d = stat_issued_q + 16'd1;
        end
        if (push && flags_have_error(alu_flags) && (stat_errors_q != 8'hFF)) begin
            stat_errors_d = stat_errors_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_issued_q <= '0;
            stat_errors_q <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_errors_q <= stat_errors_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_errors = stat_errors_q;
`else
    assign stat_issued = '0;
    assign stat_errors = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int TAGW  = 4;
`ifdef ALU_ISSUER_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic              clk, rst_n;
    logic              cmd_valid, cmd_ready;
    logic [WIDTH-1:0]  cmd_a, cmd_b;
    logic [3:0]        cmd_op;
    logic [TAGW-1:0]   cmd_tag;
    logic [WIDTH-1:0]  alu_a, alu_b;
    logic [3:0]        alu_op;
    logic [WIDTH-1:0]  alu_result;
    logic [4:0]        alu_fl;
    logic              rsp_valid, rsp_ready;
    logic [WIDTH-1:0]  rsp_result;
    logic [4:0]        rsp_flags;
    logic [TAGW-1:0]   rsp_tag;
    logic              drain_req, drain_done;
    logic [15:0]       stat_issued;
    logic [7:0]        stat_errors;

    alu_cmd_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .cmd_op         (cmd_op),
        .cmd_tag        (cmd_tag),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_op         (alu_op),
        .alu_result     (alu_result),
        .alu_overflow   (alu_fl[0]),
        .alu_underflow  (alu_fl[1]),
        .alu_invalid_op (alu_fl[2]),
        .alu_is_equal   (alu_fl[3]),
        .alu_is_less    (alu_fl[4]),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_flags      (rsp_flags),
        .rsp_tag        (rsp_tag),
        .drain_req      (drain_req),
        .drain_done     (drain_done),
        .stat_issued    (stat_issued),
        .stat_errors    (stat_errors)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ALU: {result[15:0], flags[4:0]}
    function automatic logic [20:0] alu_eval(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] op);
        logic [16:0] sum;
        logic [15:0] r;
        logic [4:0]  f;
        r = '0;
        f = '0;
        sum = {1'b0, a} + {1'b0, b};
        case (op)
            OP_ADD:    begin r = sum[15:0]; f[FLAG_OVF] = sum[16]; end
            OP_SUB:    begin r = a - b; f[FLAG_UNF] = (a < b); end
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_NOT:    r = ~a;
            OP_SHL:    r = a << b[3:0];
            OP_SHR:    r = a >> b[3:0];
            OP_CMP_EQ: r = {15'd0, a == b};
            OP_CMP_LT: r = {15'd0, a < b};
            default:   f[FLAG_INV] = 1'b1;
        endcase
        if (op <= OP_CMP_LT) begin
            f[FLAG_EQ] = (a == b);
            f[FLAG_LT] = (a < b);
        end
        return {r, f};
    endfunction

    always @(posedge clk) begin
        {alu_result, alu_fl} <= alu_eval(alu_a, alu_b, alu_op);
    end

    // Reference model: every accepted command waits in order until popped;
    // it becomes visible three steps after the step in which it was accepted.
    typedef struct {
        logic [15:0] res;
        logic [4:0]  flags;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    exp_t        mq[$];
    logic [3:0]  pop_log[$];
    int          step_no;
    int          mode;          // 0 running, 1 draining, 2 drain complete
    logic [15:0] exp_issued;
    int          exp_errors;
    logic [15:0] last_a, last_b;
    logic [3:0]  last_op;
    bit          last_acc;
    int          n_checks, n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", tag, got, exp, step_no);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input logic [3:0] tag,
                         input logic rr, input logic dr);
        cmd_valid = v;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_tag   = tag;
        rsp_ready = rr;
        drain_req = dr;
    endtask

    task automatic step();
        bit          exp_ready, exp_valid;
        int          sz;
        logic [20:0] v;
        #1;
        last_acc = 1'b0;
        if (rst_n) begin
            sz        = mq.size();
            exp_ready = (mode == 0) && (sz < DEPTH);
            exp_valid = (sz > 0) && (step_no - mq[0].acc >= 3);
            chk("cmd_ready", cmd_ready, exp_ready);
            chk("rsp_valid", rsp_valid, exp_valid);
            chk("drain_done", drain_done, mode == 2);
            if (exp_valid) begin
                chk("rsp_result", rsp_result, mq[0].res);
                chk("rsp_flags", rsp_flags, mq[0].flags);
                chk("rsp_tag", rsp_tag, mq[0].tag);
            end
            chk("alu_a", alu_a, last_a);
            chk("alu_b", alu_b, last_b);
            chk("alu_op", alu_op, last_op);
            chk("stat_issued", stat_issued, STATS_EN ? exp_issued : 16'd0);
            chk("stat_errors", stat_errors, STATS_EN ? exp_errors : 0);
            foreach (mq[i]) begin
                if ((step_no - mq[i].acc == 2) &&
                    (mq[i].flags[FLAG_OVF] || mq[i].flags[FLAG_UNF] || mq[i].flags[FLAG_INV]) &&
                    exp_errors < 255)
                    exp_errors++;
            end
            if (rsp_ready && exp_valid) begin
                pop_log.push_back(rsp_tag);
                void'(mq.pop_front());
            end
            if (cmd_valid && exp_ready) begin
                v = alu_eval(cmd_a, cmd_b, cmd_op);
                mq.push_back('{v[20:5], v[4:0], cmd_tag, step_no});
                last_a     = cmd_a;
                last_b     = cmd_b;
                last_op    = cmd_op;
                exp_issued = exp_issued + 16'd1;
                last_acc   = 1'b1;
            end
            case (mode)
                0:       if (drain_req) mode = 1;
                1:       if (sz == 0) mode = 2;
                default: mode = 0;
            endcase
        end else begin
            mq.delete();
            mode       = 0;
            exp_issued = '0;
            exp_errors = 0;
            last_a     = '0;
            last_b     = '0;
            last_op    = '0;
        end
        step_no++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rr);
        drive(1'b0, '0, '0, OP_ADD, '0, rr, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [15:0] rand_operand();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 2) return 16'hFFFF;
        if (sel < 4) return 16'h0000;
        return 16'($urandom);
    endfunction

    initial begin
        int nacc, next_tag, wait_n, err_before;
        n_checks = 0; n_fail = 0; step_no = 0; mode = 0;
        exp_issued = '0; exp_errors = 0;
        last_a = '0; last_b = '0; last_op = '0;
        rst_n = 1'b0;
        drive(1'b0, '0, '0, OP_ADD, '0, 1'b0, 1'b0);
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        idle(2, 1'b1);

        // ADD overflow returns after two clocks with the accepted tag
        drive(1'b1, 16'hFFFF, 16'h0001, OP_ADD, 4'd3, 1'b1, 1'b0);
        step();
        idle(2, 1'b1);
        chk("add_valid", rsp_valid, 1);
        chk("add_result", rsp_result, 16'h0000);
        chk("add_flags", rsp_flags, 5'b00001);
        chk("add_tag", rsp_tag, 4'd3);
        idle(3, 1'b1);

        // Back-pressure: only DEPTH commands accepted, then ordered release
        nacc = 0; next_tag = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, rand_operand(), rand_operand(), OP_SUB, 4'(next_tag), 1'b0, 1'b0);
            step();
            if (last_acc) begin nacc++; next_tag++; end
        end
        chk("bp_accepted", nacc, 4);
        chk("bp_ready_low", cmd_ready, 0);
        pop_log.delete();
        for (int i = 0; i < 30 && next_tag < 6; i++) begin
            drive(1'b1, rand_operand(), rand_operand(), OP_XOR, 4'(next_tag), 1'b1, 1'b0);
            step();
            if (last_acc) next_tag++;
        end
        chk("bp_all_accepted", next_tag, 6);
        idle(8, 1'b1);
        chk("bp_pop_count", pop_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < pop_log.size()) chk("bp_pop_order", pop_log[i], 4'(i));
        end

        // Invalid opcode
        err_before = exp_errors;
        drive(1'b1, 16'h1234, 16'h5678, 4'b1010, 4'd7, 1'b0, 1'b0);
        step();
        idle(2, 1'b0);
        chk("inv_valid", rsp_valid, 1);
        chk("inv_result", rsp_result, 16'h0000);
        chk("inv_flags", rsp_flags, 5'b00100);
        chk("inv_tag", rsp_tag, 4'd7);
        chk("inv_stat_errors", stat_errors, STATS_EN ? err_before + 1 : 0);
        idle(4, 1'b1);

        // Drain with two commands in flight
        drive(1'b1, 16'd10, 16'd3, OP_ADD, 4'd1, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'd3, 16'd10, OP_SUB, 4'd2, 1'b1, 1'b0);
        step();
        drive(1'b0, '0, '0, OP_ADD, '0, 1'b1, 1'b1);
        step();
        chk("drain_ready_drop", cmd_ready, 0);
        drive(1'b0, '0, '0, OP_ADD, '0, 1'b1, 1'b0);
        wait_n = 0;
        while (!drain_done && wait_n < 20) begin
            step();
            wait_n++;
        end
        chk("drain_done_seen", drain_done, 1);
        chk("drain_latency", wait_n, 3);
        chk("drain_empty", rsp_valid, 0);
        step();
        chk("drain_pulse_end", drain_done, 0);
        chk("drain_ready_back", cmd_ready, 1);

        // Back-to-back issue at one command per clock
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, rand_operand(), rand_operand(), 4'($urandom_range(0, 9)), 4'(i), 1'b1, 1'b0);
            step();
            if (last_acc) nacc++;
        end
        chk("b2b_accepts", nacc, 8);
        idle(5, 1'b1);

        // Reset with buffered responses
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rand_operand(), rand_operand(), OP_AND, 4'(i + 8), 1'b0, 1'b0);
            step();
        end
        idle(2, 1'b0);
        chk("rst_buffered", rsp_valid, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_stat_issued", stat_issued, 16'd0);
        chk("rst_ready", cmd_ready, 1);
        idle(6, 1'b1);

        // Randomized traffic with occasional drain and reset
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 99) < 60, rand_operand(), rand_operand(),
                  4'($urandom_range(0, 11)), 4'($urandom),
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 2);
            rst_n = ($urandom_range(0, 299) != 0);
            step();
            rst_n = 1'b1;
        end
        idle(12, 1'b1);
        chk("final_empty", rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width.
REQ-002 SHALL have parameter DEPTH, default 4, response buffer entries (power of 2, >=2).
REQ-003 SHALL have parameter TAGW, default 4, command tag width.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 cmd_valid / cmd_ready  in / out  1  command handshake.
REQ-008 cmd_a, cmd_b  in  WIDTH  operands; cmd_op  in  4  opcode; cmd_tag  in  TAGW  tag.
REQ-009 alu_a, alu_b  out  WIDTH; alu_op  out  4; registered drive of the ALU inputs.
REQ-010 alu_result  in  WIDTH; alu_overflow, alu_underflow, alu_invalid_op, alu_is_equal, alu_is_less  in  1 each; ALU registered outputs.
REQ-011 rsp_valid / rsp_ready  out / in  1  response handshake.
REQ-012 rsp_result  out  WIDTH; rsp_flags  out  5  {is_less,is_equal,invalid_op,underflow,overflow}; rsp_tag  out  TAGW.
REQ-013 drain_req  in  1  drain request; drain_done  out  1  one-cycle pulse.
REQ-014 stat_issued  out  16; stat_errors  out  8; statistics.

Function
REQ-015 Accept SHALL occur on an edge where cmd_valid && cmd_ready; alu_a/alu_b/alu_op SHALL load cmd_a/cmd_b/cmd_op on that edge and hold otherwise.
REQ-016 ALU latency is fixed at 1 register stage; the issuer SHALL capture alu_* into the response buffer on the 2nd edge after accept, with the accepted tag.
REQ-017 In-flight tracking SHALL be a 2-stage valid/tag shift pipeline (inflight 0..2).
REQ-018 cmd_ready SHALL equal (state==RUN) && (buffer_count + inflight < DEPTH); no response is ever dropped.
REQ-019 Response buffer SHALL be FIFO-ordered; rsp_valid = buffer non-empty; pop on rsp_valid && rsp_ready.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; push into full buffer is impossible by REQ-018.
REQ-021 Pointers SHALL wrap modulo DEPTH.
REQ-022 FSM states RUN, DRAIN, DONE: RUN->DRAIN on drain_req; DRAIN->DONE when inflight==0 && buffer empty; DONE->RUN unconditionally next cycle.
REQ-023 drain_done SHALL be high only in DONE; cmd_ready SHALL be low in DRAIN and DONE.
REQ-024 drain_req while already in DRAIN/DONE SHALL be ignored.
REQ-025 Back-to-back accepts SHALL sustain 1 command/clock when rsp_ready is held high.

Reset
REQ-026 With rst_n low at an edge: state RUN, buffer empty, inflight 0, alu_a/alu_b 0, alu_op 4'b0000, rsp_valid 0, drain_done 0, stat_* 0.
REQ-027 Reset mid-operation SHALL discard all in-flight and buffered responses; cmd_ready SHALL reassert the cycle after rst_n rises.

Configuration
REQ-028 Macro ALU_ISSUER_STATS_EN defined: stat_issued SHALL increment per accept (wrap at 2^16); stat_errors SHALL increment per captured response with invalid_op, overflow or underflow set, saturating at 255.
REQ-029 Macro undefined: stat_issued and stat_errors SHALL be constant 0 and counter logic absent.

Structure
REQ-030 Shared package alu_pkg SHALL hold opcode constants (ADD 0000 ... CMP_LT 1001), flag bit indices, and the FSM state typedef.
REQ-031 Response buffer SHALL be sub-module alu_rsp_fifo (params WIDTH+5+TAGW data, DEPTH).

Verification
REQ-032 ADD a=0xFFFF b=0x0001 tag=3, rsp_ready=1 -> rsp_valid 2 clocks after accept, rsp_result 0x0000, rsp_flags 5'b00001, rsp_tag 3.
REQ-033 rsp_ready=0, present 6 commands tags 0..5, DEPTH=4 -> exactly 4 accepted, cmd_ready low; release rsp_ready -> tags 0,1,2,3 in order, then 4,5 accepted.
REQ-034 op=4'b1010 -> rsp_result 0x0000, rsp_flags 5'b00100; with ALU_ISSUER_STATS_EN, stat_errors 0->1; without, stays 0.
REQ-035 drain_req with 2 in flight, rsp_ready=1 -> cmd_ready low immediately, drain_done one-cycle pulse after 2nd response pops, cmd_ready high next cycle.
REQ-036 3 responses buffered, rst_n low one edge -> rsp_valid 0, stat_issued 0; no stale response after reset release.
